// File: rtl/wb_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin arbiter sharing the frame-buffer write port among the
//            Julia workers. Optional coordinate check under WB_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module wb_arbiter #(
    parameter int unsigned NUM_WORKERS = 16,
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 10,
    parameter int unsigned ITER_BITS   = 8,
    parameter int unsigned FB_WIDTH    = 640,
    parameter int unsigned FB_HEIGHT   = 480,
    parameter int unsigned ADDR_BITS   = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WORKERS-1:0] wb_req,
    input  logic [X_BITS-1:0]      wb_x    [NUM_WORKERS],
    input  logic [Y_BITS-1:0]      wb_y    [NUM_WORKERS],
    input  logic [ITER_BITS-1:0]   wb_iter [NUM_WORKERS],
    output logic [NUM_WORKERS-1:0] wb_ack,
    output logic                   mem_wr,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [ITER_BITS-1:0]   mem_wdata,
    input  logic                   mem_busy,
    output logic [ADDR_BITS-1:0]   pixel_count,
    output logic                   frame_done,
    output logic                   err
);

    localparam int unsigned            c_SEL_W      = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam logic [ADDR_BITS-1:0]   c_FB_W       = ADDR_BITS'(FB_WIDTH);
    localparam logic [ADDR_BITS-1:0]   c_FRAME_LAST = ADDR_BITS'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [c_SEL_W-1:0]     c_RR_INIT    = c_SEL_W'(NUM_WORKERS - 1);
    localparam logic [NUM_WORKERS-1:0] c_ONE        = NUM_WORKERS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                 r_state,  w_state_nxt;
    logic [c_SEL_W-1:0]     r_rr_ptr, w_rr_nxt;
    logic [X_BITS-1:0]      r_x,      w_x_nxt;
    logic [Y_BITS-1:0]      r_y,      w_y_nxt;
    logic [ITER_BITS-1:0]   r_iter,   w_iter_nxt;
    logic [NUM_WORKERS-1:0] r_ack,    w_ack_nxt;
    logic [ADDR_BITS-1:0]   r_addr,   w_addr_nxt;
    logic [ITER_BITS-1:0]   r_wdata,  w_wdata_nxt;
    logic [ADDR_BITS-1:0]   r_count,  w_count_nxt;
    logic                   r_done,   w_done_nxt;

    logic                   w_found;
    logic [c_SEL_W-1:0]     w_sel;
    logic [c_SEL_W-1:0]     w_cand;
    logic [ADDR_BITS-1:0]   w_addr_calc;

    // Search starts just above the last winner so it drops to lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= NUM_WORKERS; i++) begin
            w_cand = c_SEL_W'((32'(r_rr_ptr) + i) % NUM_WORKERS);
            if (!w_found && wb_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_addr_calc = ADDR_BITS'(r_y) * c_FB_W + ADDR_BITS'(r_x);

`ifdef WB_BOUNDS_CHECK_EN
    logic r_err, w_err_nxt;
    logic w_oob;
    assign w_oob = (32'(r_x) >= FB_WIDTH) || (32'(r_y) >= FB_HEIGHT);
    assign err   = r_err;
`else
    assign err   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_iter_nxt  = r_iter;
        w_ack_nxt   = '0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
`ifdef WB_BOUNDS_CHECK_EN
        w_err_nxt   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_x_nxt     = wb_x[w_sel];
                    w_y_nxt     = wb_y[w_sel];
                    w_iter_nxt  = wb_iter[w_sel];
                    w_rr_nxt    = w_sel;
                    w_ack_nxt   = c_ONE << w_sel;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_addr_nxt  = w_addr_calc;
                w_wdata_nxt = r_iter;
                w_state_nxt = S_WRITE;
`ifdef WB_BOUNDS_CHECK_EN
                if (w_oob) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_WRITE: begin
                if (!mem_busy) begin
                    w_state_nxt = S_IDLE;
                    if (r_count == c_FRAME_LAST) begin
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = r_count + ADDR_BITS'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= c_RR_INIT;
            r_x      <= '0;
            r_y      <= '0;
            r_iter   <= '0;
            r_ack    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
`ifdef WB_BOUNDS_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_iter   <= w_iter_nxt;
            r_ack    <= w_ack_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
`ifdef WB_BOUNDS_CHECK_EN
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign wb_ack      = r_ack;
    assign mem_wr      = (r_state == S_WRITE);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign pixel_count = r_count;
    assign frame_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// Scoreboard bench for wb_arbiter: expected acks and writes are queued when a
// request is posted and popped by monitors as the DUT produces them.
module tb_wb_arbiter;

    localparam int NW    = 16;
    localparam int XB    = 10;
    localparam int YB    = 10;
    localparam int IB    = 8;
    localparam int FBW   = 640;
    localparam int FBH   = 4;
    localparam int AB    = 19;
    localparam int FRAME = FBW * FBH;
`ifdef WB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          tb_clk = 1'b0;
    logic          rst;
    logic [NW-1:0] wb_req;
    logic [XB-1:0] wb_x    [NW];
    logic [YB-1:0] wb_y    [NW];
    logic [IB-1:0] wb_iter [NW];
    logic [NW-1:0] wb_ack;
    logic          mem_wr;
    logic [AB-1:0] mem_addr;
    logic [IB-1:0] mem_wdata;
    logic          mem_busy;
    logic [AB-1:0] pixel_count;
    logic          frame_done;
    logic          err;

    wb_arbiter #(
        .NUM_WORKERS(NW), .X_BITS(XB), .Y_BITS(YB), .ITER_BITS(IB),
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_BITS(AB)
    ) dut (
        .clk(tb_clk), .rst(rst), .wb_req(wb_req), .wb_x(wb_x), .wb_y(wb_y),
        .wb_iter(wb_iter), .wb_ack(wb_ack), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_busy(mem_busy), .pixel_count(pixel_count),
        .frame_done(frame_done), .err(err)
    );

    always #5 tb_clk = ~tb_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [NW-1:0]    ack_q [$];
    logic [AB+IB-1:0] wr_q  [$];

    always @(posedge tb_clk) cyc++;

    always @(negedge tb_clk) begin : ack_mon
        logic [NW-1:0] e;
        if (wb_ack !== '0) begin
            n_checks++;
            if (ack_q.size() == 0) begin
                $display("FAIL ack_unexpected: got %h, expected none", wb_ack);
            end else begin
                e = ack_q.pop_front();
                if (wb_ack !== e) $display("FAIL ack_order: got %h, expected %h", wb_ack, e);
                else n_pass++;
            end
        end
    end

    always @(negedge tb_clk) begin : wr_mon
        logic [AB+IB-1:0] e;
        if (mem_wr === 1'b1 && mem_busy === 1'b0 && rst === 1'b0) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr %0d data %h, expected none", mem_addr, mem_wdata);
            end else begin
                e = wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== e)
                    $display("FAIL write_data: got addr %0d data %h, expected addr %0d data %h",
                             mem_addr, mem_wdata, e[AB+IB-1:IB], e[IB-1:0]);
                else n_pass++;
            end
        end
    end

    always @(negedge tb_clk) if (frame_done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        wb_req = '0;
        mem_busy = 1'b0;
        ack_q.delete();
        wr_q.delete();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge tb_clk);
            if (ack_q.size() == 0 && wr_q.size() == 0) begin
                @(negedge tb_clk);
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic post_pixel(input int w, input int x, input int y, input int it, input bit exp_write);
        wb_x[w]    = XB'(x);
        wb_y[w]    = YB'(y);
        wb_iter[w] = IB'(it);
        ack_q.push_back(NW'(1) << w);
        if (exp_write) wr_q.push_back({AB'(y * FBW + x), IB'(it)});
        wb_req[w] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk);
            if (wb_ack !== '0) break;
        end
        step();
        wb_req[w] = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge tb_clk);
        n_checks++;
        if (wb_ack !== '0 || mem_wr !== 1'b0) $display("FAIL reset_ack_wr: got ack %h wr %b, expected 0 0", wb_ack, mem_wr);
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_mem: got addr %0d data %h, expected 0 0", mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (pixel_count !== '0 || frame_done !== 1'b0) $display("FAIL reset_count: got count %0d done %b, expected 0 0", pixel_count, frame_done);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b, expected 0", err);
        else n_pass++;
    endtask

    task automatic test_single();
        int  wr_cycles;
        bit  ok;
        post_pixel(0, 5, 2, 8'h3C, 1'b1);
        wr_cycles = 0;
        repeat (6) begin
            @(negedge tb_clk);
            if (mem_wr === 1'b1) wr_cycles++;
        end
        n_checks++;
        if (wr_cycles != 1) $display("FAIL single_wr_width: got %0d cycles, expected 1", wr_cycles);
        else n_pass++;
        wait_drain(20, ok);
        n_checks++;
        if (!ok) $display("FAIL single_drain: got pending ack %0d wr %0d, expected 0 0", ack_q.size(), wr_q.size());
        else n_pass++;
        n_checks++;
        if (pixel_count !== AB'(1)) $display("FAIL single_count: got %0d, expected 1", pixel_count);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int prev;
        bit ok;
        apply_reset();
        for (int i = 0; i < NW; i++) begin
            wb_x[i] = XB'(i);
            wb_y[i] = YB'(1);
            wb_iter[i] = IB'(8'h10 + i);
        end
        for (int g = 0; g <= NW; g++) begin
            ack_q.push_back(NW'(1) << (g % NW));
            wr_q.push_back({AB'(FBW + g % NW), IB'(8'h10 + g % NW)});
        end
        wb_req = '1;
        prev = 0;
        for (int g = 0; g <= NW; g++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge tb_clk);
                if (wb_ack !== '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!ok) $display("FAIL rr_grant_timeout: grant %0d not seen, expected within 10 cycles", g);
            else if (g > 0 && cyc - prev != 3) $display("FAIL rr_spacing: got %0d cycles, expected 3 (grant %0d)", cyc - prev, g);
            else n_pass++;
            prev = cyc;
        end
        step();
        wb_req = '0;
        wait_drain(30, ok);
        n_checks++;
        if (!ok) $display("FAIL rr_drain: got pending ack %0d wr %0d, expected 0 0", ack_q.size(), wr_q.size());
        else n_pass++;
        n_checks++;
        if (pixel_count !== AB'(NW + 1)) $display("FAIL rr_count: got %0d, expected %0d", pixel_count, NW + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [AB-1:0] a0, c0;
        logic [IB-1:0] d0;
        bit stable;
        step();
        mem_busy = 1'b1;
        post_pixel(3, 100, 3, 8'hA5, 1'b1);
        c0 = pixel_count;
        @(negedge tb_clk);
        a0 = mem_addr;
        d0 = mem_wdata;
        stable = (mem_wr === 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step();
            if (k == 5) mem_busy = 1'b0;
            @(negedge tb_clk);
            if (mem_wr !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL bp_stable: got wr %b addr %0d data %h, expected 1 %0d %h", mem_wr, mem_addr, mem_wdata, a0, d0);
        else n_pass++;
        n_checks++;
        if (pixel_count !== c0) $display("FAIL bp_count_hold: got %0d, expected %0d", pixel_count, c0);
        else n_pass++;
        @(negedge tb_clk);
        n_checks++;
        if (mem_wr !== 1'b0 || pixel_count !== c0 + AB'(1))
            $display("FAIL bp_release: got wr %b count %0d, expected 0 %0d", mem_wr, pixel_count, c0 + 1);
        else n_pass++;
    endtask

    task automatic test_bounds();
        logic [AB-1:0] c0;
        int wr_cycles;
        bit ok;
        c0 = pixel_count;
        post_pixel(2, 640, 0, 8'h55, !BOUNDS);
        wr_cycles = 0;
        repeat (8) begin
            @(negedge tb_clk);
            if (mem_wr === 1'b1) wr_cycles++;
        end
        n_checks++;
        if (wr_cycles != (BOUNDS ? 0 : 1)) $display("FAIL bounds_wr: got %0d write cycles, expected %0d", wr_cycles, BOUNDS ? 0 : 1);
        else n_pass++;
        n_checks++;
        if (err !== BOUNDS) $display("FAIL bounds_err: got %b, expected %b", err, BOUNDS);
        else n_pass++;
        n_checks++;
        if (pixel_count !== c0 + AB'(BOUNDS ? 0 : 1)) $display("FAIL bounds_count: got %0d, expected %0d", pixel_count, c0 + (BOUNDS ? 0 : 1));
        else n_pass++;
        post_pixel(2, 1, 0, 8'h11, 1'b1);
        wait_drain(20, ok);
        n_checks++;
        if (!ok || err !== BOUNDS) $display("FAIL bounds_sticky: got err %b drained %b, expected %b 1", err, ok, BOUNDS);
        else n_pass++;
    endtask

    task automatic test_reset_during_write();
        int wr_cycles;
        bit ok;
        step();
        mem_busy = 1'b1;
        post_pixel(5, 10, 1, 8'h77, 1'b0);
        @(negedge tb_clk);
        n_checks++;
        if (mem_wr !== 1'b1) $display("FAIL rstw_in_write: got wr %b, expected 1", mem_wr);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_wr !== 1'b0 || pixel_count !== '0 || err !== 1'b0)
            $display("FAIL rstw_async: got wr %b count %0d err %b, expected 0 0 0", mem_wr, pixel_count, err);
        else n_pass++;
        repeat (2) step();
        rst = 1'b0;
        mem_busy = 1'b0;
        wr_cycles = 0;
        repeat (3) begin
            @(negedge tb_clk);
            if (mem_wr === 1'b1) wr_cycles++;
        end
        n_checks++;
        if (wr_cycles != 0) $display("FAIL rstw_abandon: got %0d write cycles, expected 0", wr_cycles);
        else n_pass++;
        wb_x[0] = XB'(2); wb_y[0] = '0; wb_iter[0] = 8'h21;
        wb_x[7] = XB'(3); wb_y[7] = '0; wb_iter[7] = 8'h27;
        ack_q.push_back(NW'(16'h0001));
        ack_q.push_back(NW'(16'h0080));
        wr_q.push_back({AB'(2), 8'h21});
        wr_q.push_back({AB'(3), 8'h27});
        wb_req = NW'(16'h0081);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge tb_clk);
                if (wb_ack !== '0) break;
            end
            step();
            wb_req[w == 0 ? 0 : 7] = 1'b0;
        end
        wait_drain(20, ok);
        n_checks++;
        if (!ok || pixel_count !== AB'(2))
            $display("FAIL rstw_regrant: got count %0d drained %b, expected 2 1", pixel_count, ok);
        else n_pass++;
    endtask

    task automatic test_frame_wrap();
        int got;
        bit ok;
        apply_reset();
        wb_x[0] = XB'(1); wb_y[0] = YB'(1); wb_iter[0] = 8'h07;
        for (int i = 0; i < FRAME - 1; i++) begin
            ack_q.push_back(NW'(1));
            wr_q.push_back({AB'(FBW + 1), 8'h07});
        end
        done_cnt = 0;
        got = 0;
        wb_req[0] = 1'b1;
        for (int i = 0; i < 3 * FRAME + 100; i++) begin
            @(negedge tb_clk);
            if (wb_ack !== '0) got++;
            if (got == FRAME - 1) break;
        end
        step();
        wb_req[0] = 1'b0;
        wait_drain(50, ok);
        n_checks++;
        if (!ok || got != FRAME - 1) $display("FAIL wrap_preload: got %0d grants drained %b, expected %0d 1", got, ok, FRAME - 1);
        else n_pass++;
        n_checks++;
        if (pixel_count !== AB'(FRAME - 1) || done_cnt != 0)
            $display("FAIL wrap_before: got count %0d done %0d, expected %0d 0", pixel_count, done_cnt, FRAME - 1);
        else n_pass++;
        post_pixel(0, 4, 2, 8'h99, 1'b1);
        wait_drain(20, ok);
        repeat (3) @(negedge tb_clk);
        n_checks++;
        if (done_cnt != 1) $display("FAIL wrap_done_pulse: got %0d cycles high, expected 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (!ok || pixel_count !== '0) $display("FAIL wrap_count: got %0d drained %b, expected 0 1", pixel_count, ok);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        wb_req = '0;
        mem_busy = 1'b0;
        for (int i = 0; i < NW; i++) begin
            wb_x[i] = '0;
            wb_y[i] = '0;
            wb_iter[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bounds();
        test_reset_during_write();
        test_frame_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
